// File: rtl/apb4_regbank_pkg.sv
// Shared constants, FSM encoding and decode record for the APB4 register bank.
// Register offsets are byte addresses; CTRL carries only the wait-state field.
package apb4_regbank_pkg;

    localparam int ID_OFS       = 'h00;
    localparam int CTRL_OFS     = 'h04;
    localparam int WRCNT_OFS    = 'h08;
    localparam int SCRATCH_BASE = 'h10;

    localparam int WAIT_W = 4;
    localparam int DATA_W = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    typedef struct packed {
        logic is_id;
        logic is_ctrl;
        logic is_wrcnt;
        logic is_scr;
        logic err;
    } apb_dec_t;

endpackage

// File: rtl/apb4_slave_ctrl.sv
// IDLE/ACCESS transfer FSM with a programmable wait counter; the wait count is
// latched at the setup edge so CTRL writes only affect the following transfer.
module apb4_slave_ctrl
    import apb4_regbank_pkg::*;
(
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic [WAIT_W-1:0] wait_cfg,
    output logic              pready,
    output logic              commit
);

    apb_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_lat, wait_cnt;
    logic              setup;

    assign setup = (state == IDLE) && psel && !penable;

    always_ff @(posedge pclk) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            wait_lat <= '0;
            wait_cnt <= '0;
        end else if (setup) begin
            wait_lat <= wait_cfg;
            wait_cnt <= '0;
        end else if (state == ACCESS && !pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (setup) state_nxt = ACCESS;
            ACCESS:  if (!psel || commit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pready = (state == ACCESS) && (wait_cnt == wait_lat);
        commit = pready && psel && penable;
    end

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer: ID, CTRL (wait states), write counter and byte-writable scratch
// registers; illegal accesses complete with pslverr and leave state untouched.
module apb4_slave_regbank
    import apb4_regbank_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [31:0] ID_VALUE    = 32'hA4B0_0001
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [2:0]            pprot,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [3:0]            pstrb,
    output logic                  pready,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pslverr
);

    localparam int SIDX_W = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    logic [WAIT_W-1:0]                  ctrl_wait;
    logic [DATA_W-1:0]                  wrcnt;
    logic [NUM_SCRATCH-1:0][DATA_W-1:0] scratch;
    logic [ADDR_WIDTH-1:0]              sofs;
    logic [SIDX_W-1:0]                  sidx;
    logic [DATA_W-1:0]                  rdata_mux;
    apb_dec_t                           dec;
    logic                               commit, wr_en;
    logic                               unused_ok;

    apb4_slave_ctrl u_ctrl (
        .pclk     (pclk),
        .presetn  (presetn),
        .psel     (psel),
        .penable  (penable),
        .wait_cfg (ctrl_wait),
        .pready   (pready),
        .commit   (commit)
    );

    always_comb begin
        sofs         = paddr - ADDR_WIDTH'(SCRATCH_BASE);
        sidx         = sofs[SIDX_W+1:2];
        dec          = '0;
        dec.is_id    = (paddr == ADDR_WIDTH'(ID_OFS));
        dec.is_ctrl  = (paddr == ADDR_WIDTH'(CTRL_OFS));
        dec.is_wrcnt = (paddr == ADDR_WIDTH'(WRCNT_OFS));
        dec.is_scr   = (paddr[1:0] == 2'b00) && (paddr >= ADDR_WIDTH'(SCRATCH_BASE))
                       && (sofs[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(NUM_SCRATCH));
        dec.err      = (paddr[1:0] != 2'b00)
                       || !(dec.is_id || dec.is_ctrl || dec.is_wrcnt || dec.is_scr)
                       || (pwrite && (dec.is_id || dec.is_wrcnt));
    end

    assign wr_en     = commit && pwrite && !dec.err;
    assign unused_ok = ^{pprot, sofs[1:0]};

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            ctrl_wait <= '0;
            wrcnt     <= '0;
        end else if (wr_en) begin
            wrcnt <= wrcnt + 1'b1;
            if (dec.is_ctrl && pstrb[0]) ctrl_wait <= pwdata[WAIT_W-1:0];
        end
    end

    for (genvar i = 0; i < NUM_SCRATCH; i++) begin : g_scr
        always_ff @(posedge pclk) begin
            if (!presetn) begin
                scratch[i] <= '0;
            end else if (wr_en && dec.is_scr && sidx == SIDX_W'(i)) begin
                for (int b = 0; b < 4; b++)
                    if (pstrb[b]) scratch[i][8*b +: 8] <= pwdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata_mux = '0;
        if (dec.is_id)    rdata_mux = ID_VALUE;
        if (dec.is_ctrl)  rdata_mux = {{(DATA_W-WAIT_W){1'b0}}, ctrl_wait};
        if (dec.is_wrcnt) rdata_mux = wrcnt;
        if (dec.is_scr)   rdata_mux = scratch[sidx];
    end

    // Error and data only surface in the completing cycle.
    assign pslverr = pready && dec.err;
    assign prdata  = (pready && !dec.err) ? rdata_mux : '0;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Directed bench: a table of APB transfers with hand-computed results, plus
// hand-written reset-during-transfer and aborted-transfer sequences.
module tb_apb4_slave_regbank;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [11:0] paddr;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;

    int checks = 0;
    int errors = 0;

    apb4_slave_regbank dut (
        .pclk    (pclk),
        .presetn (presetn),
        .paddr   (paddr),
        .pprot   (pprot),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_waits;
    } vec_t;

    vec_t vecs[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives setup then access; leaves psel high so the next call is back-to-back.
    task automatic xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, output logic [31:0] rd, output logic er,
                        output int nw);
        logic done;
        done = 1'b0;
        rd = '0;
        er = 1'b0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = sb;
        pprot = 3'(a[4:2]);
        @(negedge pclk);
        penable = 1'b1;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (pready) begin
                rd = prdata; er = pslverr; done = 1'b1;
                break;
            end
            nw++;
            @(negedge pclk);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: pready never rose for addr 0x%03h", a);
        end
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a,
                          input logic [31:0] exp, input int exp_w);
        logic [31:0] rd; logic er; int nw;
        xfer(1'b0, a, 32'h0, 4'h0, rd, er, nw);
        chk({name, " rdata"}, rd, exp);
        chk({name, " err"}, 32'(er), 32'd0);
        chk({name, " waits"}, 32'(nw), 32'(exp_w));
    endtask

    initial begin
        logic [31:0] rd; logic er; int nw;
        vecs[0]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'hA4B0_0001, 1'b0, 0};
        vecs[1]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,         1'b0, 0};
        vecs[2]  = '{1'b1, 12'h010, 32'h00000055, 4'h1, 32'h0,         1'b0, 0};
        vecs[3]  = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBE55,  1'b0, 0};
        vecs[4]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'd2,         1'b0, 0};
        vecs[5]  = '{1'b1, 12'h004, 32'h00000003, 4'hF, 32'h0,         1'b0, 0};
        vecs[6]  = '{1'b0, 12'h014, 32'h0,        4'h0, 32'h0,         1'b0, 3};
        vecs[7]  = '{1'b1, 12'h000, 32'h11111111, 4'hF, 32'h0,         1'b1, 3};
        vecs[8]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h0,         1'b1, 3};
        vecs[9]  = '{1'b0, 12'h012, 32'h0,        4'h0, 32'h0,         1'b1, 3};
        vecs[10] = '{1'b0, 12'h000, 32'h0,        4'h0, 32'hA4B0_0001, 1'b0, 3};
        vecs[11] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'd3,         1'b0, 3};
        vecs[12] = '{1'b1, 12'h018, 32'hAABBCCDD, 4'h6, 32'h0,         1'b0, 3};
        vecs[13] = '{1'b0, 12'h018, 32'h0,        4'h0, 32'h00BBCC00,  1'b0, 3};
        vecs[14] = '{1'b1, 12'h01C, 32'h12345678, 4'h0, 32'h0,         1'b0, 3};
        vecs[15] = '{1'b0, 12'h01C, 32'h0,        4'h0, 32'h0,         1'b0, 3};
        vecs[16] = '{1'b1, 12'h004, 32'hFFFFFFF5, 4'hE, 32'h0,         1'b0, 3};
        vecs[17] = '{1'b0, 12'h004, 32'h0,        4'h0, 32'd3,         1'b0, 3};
        vecs[18] = '{1'b1, 12'h004, 32'hFFFFFFF0, 4'h1, 32'h0,         1'b0, 3};
        vecs[19] = '{1'b0, 12'h004, 32'h0,        4'h0, 32'd0,         1'b0, 0};
        vecs[20] = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h0,         1'b1, 0};
        vecs[21] = '{1'b1, 12'h00C, 32'h1,        4'hF, 32'h0,         1'b1, 0};
        vecs[22] = '{1'b1, 12'h008, 32'h1,        4'hF, 32'h0,         1'b1, 0};
        vecs[23] = '{1'b0, 12'h008, 32'h0,        4'h0, 32'd7,         1'b0, 0};
        vecs[24] = '{1'b1, 12'h011, 32'h0,        4'hF, 32'h0,         1'b1, 0};
        vecs[25] = '{1'b0, 12'h010, 32'h0,        4'h0, 32'hDEADBE55,  1'b0, 0};

        // Reset with a live-looking bus: outputs must stay quiet.
        presetn = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 12'h000; pwdata = '0; pstrb = '0; pprot = '0;
        repeat (3) @(negedge pclk);
        #1;
        chk("reset pready", 32'(pready), 32'd0);
        chk("reset pslverr", 32'(pslverr), 32'd0);
        chk("reset prdata", prdata, 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;

        for (int v = 0; v < 26; v++) begin
            xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].strb, rd, er, nw);
            chk($sformatf("vec%0d err", v), 32'(er), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d waits", v), 32'(nw), 32'(vecs[v].exp_waits));
            if (!vecs[v].wr || vecs[v].exp_err)
                chk($sformatf("vec%0d rdata", v), rd, vecs[v].exp_rd);
        end
        idle();

        // Reset in the middle of a WAIT=5 write to SCRATCH[2].
        xfer(1'b1, 12'h004, 32'h5, 4'hF, rd, er, nw);
        chk("ctrl5 err", 32'(er), 32'd0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h018;
        pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        repeat (2) @(negedge pclk);
        presetn = 1'b0;
        #1;
        chk("rst-mid pready pre-edge", 32'(pready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge pclk);
            #1;
            chk($sformatf("rst-mid pready c%0d", c), 32'(pready), 32'd0);
            chk($sformatf("rst-mid pslverr c%0d", c), 32'(pslverr), 32'd0);
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        rd_chk("post-rst scratch2", 12'h018, 32'h0, 0);
        rd_chk("post-rst ctrl", 12'h004, 32'h0, 0);
        rd_chk("post-rst wrcnt", 12'h008, 32'h0, 0);
        idle();

        // Abort a WAIT=4 write to SCRATCH[0] during its second wait cycle.
        xfer(1'b1, 12'h004, 32'h4, 4'hF, rd, er, nw);
        chk("ctrl4 err", 32'(er), 32'd0);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        chk("abort wait1 pready", 32'(pready), 32'd0);
        @(negedge pclk);
        #1;
        chk("abort wait2 pready", 32'(pready), 32'd0);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        #1;
        chk("abort idle pready", 32'(pready), 32'd0);
        rd_chk("abort scratch0", 12'h010, 32'h0, 4);
        rd_chk("abort wrcnt", 12'h008, 32'd1, 4);
        idle();

        repeat (2) @(negedge pclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
